// File: rtl/cnn_mem_pkg.sv
// Shared types and default layer constants for the CNN weight stores.
package cnn_mem_pkg;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_LANES  = 8;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_ROW_W  = DEF_WORD_W * DEF_LANES;

   typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;
   typedef logic [$clog2(DEF_DEPTH)-1:0] row_idx_t;
   typedef logic [DEF_ROW_W-1:0]         row_t;

   // Per-layer fill depth and port-2 bank offset
   localparam int L1_ROWS_USED   = 50;
   localparam int L1_BANK_OFFSET = 25;
   localparam int L2_ROWS_USED   = 32;
   localparam int L2_BANK_OFFSET = 16;

   function automatic int row_width(input int word_w, input int lanes);
      return word_w * lanes;
   endfunction

endpackage

// File: rtl/weight_pack_ram.sv
// Row array with per-lane write enables and two registered read ports.
module weight_pack_ram
   import cnn_mem_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int LANES  = DEF_LANES,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AW     = $clog2(DEPTH),
   parameter int ROW_W  = row_width(WORD_W, LANES)
) (
   input  logic              clk,
   input  logic [LANES-1:0]  we_lane,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr1,
   input  logic [AW-1:0]     raddr2,
   output logic [ROW_W-1:0]  rdata1,
   output logic [ROW_W-1:0]  rdata2
);

   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [ROW_W-1:0] rd1_q;
   logic [ROW_W-1:0] rd2_q;

   // Reads sample the array before this edge's writes land
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (we_lane[k]) begin
            mem_q[waddr][k*WORD_W +: WORD_W] <= wdata;
         end
      end
      if (re) begin
         rd1_q <= mem_q[raddr1];
         rd2_q <= mem_q[raddr2];
      end
   end

   assign rdata1 = rd1_q;
   assign rdata2 = rd2_q;

endmodule

// File: rtl/weight_local_mem_pack.sv
// Per-layer weight store: packs serial words into rows, dual-row reads.
module weight_local_mem_pack
   import cnn_mem_pkg::*;
#(
   parameter int WORD_W      = DEF_WORD_W,
   parameter int LANES       = DEF_LANES,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int ROWS_USED   = L1_ROWS_USED,
   parameter int BANK_OFFSET = L1_BANK_OFFSET,
   parameter int AW          = $clog2(DEPTH),
   parameter int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WORD_W-1:0]         wr_data,
   input  logic                      wr_flush,
   input  logic                      wr_clear,
   input  logic                      rd_en,
   input  logic [15:0]               rd_addr1,
   input  logic [15:0]               rd_addr2,
   output logic [WORD_W*LANES-1:0]   rd_data1,
   output logic [WORD_W*LANES-1:0]   rd_data2,
   output logic                      rd_valid,
   output logic [1:0]                rd_err,
   output logic                      store_done,
   output logic [AW-1:0]             wr_row,
   output logic [LW-1:0]             wr_lane
);

   localparam int ROW_W = WORD_W * LANES;

   logic [AW-1:0]    row_q, row_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic             done_q, done_d;
   logic             close_row;
   logic [LANES-1:0] lane_we;

   logic [16:0]      r1, r2;
   logic             oob1, oob2;
   logic             valid_q, valid_d;
   logic [1:0]       err_q, err_d;
   logic [1:0]       ok_q, ok_d;
   logic [ROW_W-1:0] ram_d1, ram_d2;

   always_comb begin
      row_d     = row_q;
      lane_d    = lane_q;
      done_d    = done_q;
      close_row = 1'b0;
      if (wr_clear) begin
         row_d  = '0;
         lane_d = '0;
         done_d = 1'b0;
      end else begin
         if (wr_en) begin
            if (lane_q == LW'(LANES - 1)) begin
               close_row = 1'b1;
            end else begin
               lane_d = lane_q + 1'b1;
            end
         end
         // A flush on an empty row is a no-op unless a word lands now
         if (wr_flush && (wr_en || lane_q != '0)) begin
            close_row = 1'b1;
         end
         if (close_row) begin
            lane_d = '0;
            if (row_q == AW'(ROWS_USED - 1)) begin
               row_d  = '0;
               done_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      lane_we = '0;
      if (wr_en && !wr_clear) begin
         lane_we[lane_q] = 1'b1;
      end
   end

   assign r1   = {1'b0, rd_addr1};
   assign r2   = {1'b0, rd_addr2} + 17'(BANK_OFFSET);
   assign oob1 = (r1 >= 17'(DEPTH));
   assign oob2 = (r2 >= 17'(DEPTH));

   always_comb begin
      valid_d = rd_en;
      err_d   = err_q;
      ok_d    = ok_q;
      if (rd_en) begin
         err_d = {oob2, oob1};
         ok_d  = {~oob2, ~oob1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q   <= '0;
         lane_q  <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= '0;
         ok_q    <= '0;
      end else begin
         row_q   <= row_d;
         lane_q  <= lane_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ok_q    <= ok_d;
      end
   end

   weight_pack_ram #(
      .WORD_W (WORD_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .ROW_W  (ROW_W)
   ) u_ram (
      .clk     (clk),
      .we_lane (lane_we),
      .waddr   (row_q),
      .wdata   (wr_data),
      .re      (rd_en),
      .raddr1  (r1[AW-1:0]),
      .raddr2  (r2[AW-1:0]),
      .rdata1  (ram_d1),
      .rdata2  (ram_d2)
   );

   // ok flags zero the unreset RAM outputs after reset and on bad rows
   assign rd_data1   = ok_q[0] ? ram_d1 : '0;
   assign rd_data2   = ok_q[1] ? ram_d2 : '0;
   assign rd_valid   = valid_q;
   assign rd_err     = err_q;
   assign store_done = done_q;
   assign wr_row     = row_q;
   assign wr_lane    = lane_q;

endmodule

// File: doc/weight_local_mem_pack.md
Name: weight_local_mem_pack

Overview:
Parametrised per-layer weight store for the CNN accelerator. Accepts a serial stream of WORD_W-bit weights, packs LANES consecutive weights into one wide row, and serves two independent row reads per cycle: port 1 directly, port 2 through a fixed bank offset, so one fetch yields weights for two output kernels. It generalises the fixed 8-lane / 50-row layer weight stores, and adds flush, synchronous clear, store-done status, registered read-valid and address-error flags.

Parameters:
WORD_W, 16, width of one weight word
LANES, 8, weights packed per row; row width = WORD_W*LANES
DEPTH, 64, physical rows
ROWS_USED, 50, rows filled before write pointer wraps; 1..DEPTH
BANK_OFFSET, 25, row offset added to port-2 read address
AW, $clog2(DEPTH), row address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  one weight word valid this cycle
wr_data  in  WORD_W  weight word
wr_flush  in  1  close current partial row, advance to next row
wr_clear  in  1  synchronous pointer clear
rd_en  in  1  read request, both ports
rd_addr1  in  16  port-1 row address
rd_addr2  in  16  port-2 row address before offset
rd_data1  out  WORD_W*LANES  port-1 row
rd_data2  out  WORD_W*LANES  port-2 row
rd_valid  out  1  rd_data1/2 valid
rd_err  out  2  [0] port-1 address out of range, [1] port-2 address out of range; valid with rd_valid
store_done  out  1  sticky: ROWS_USED rows written
wr_row  out  AW  current write row pointer
wr_lane  out  $clog2(LANES)  current write lane pointer

Behaviour:
- Reset (rst=0, async): wr_row=0, wr_lane=0, store_done=0, rd_valid=0, rd_err=0, rd_data1/2=0. Memory contents are not reset.
- Write: on wr_en, wr_data goes to lane wr_lane of row wr_row. Lane k occupies bits [k*WORD_W +: WORD_W]. The write is per lane; other lanes of the row are untouched.
- Pointers after a write: wr_lane increments. From LANES-1, wr_lane goes to 0 and wr_row increments.
- Row wrap: completing a row at wr_row=ROWS_USED-1 sets wr_row=0 and store_done=1.
- wr_flush: wr_lane=0 and wr_row advances with the same wrap and store_done rule. Unwritten lanes keep their old contents.
  - wr_flush with wr_lane=0 and no wr_en: no effect.
  - wr_en and wr_flush together: the word is written first, then the row is closed. Exactly one row advance.
- wr_clear: wr_row=0, wr_lane=0, store_done=0. Highest priority; a wr_en in the same cycle is dropped.
- Read, latency 1: on rd_en at edge N, rd_data1/2 and rd_err are registered. rd_valid=1 in the cycle after edge N. With rd_en low, rd_valid=0 and data holds its last value.
- Port-1 row: r1=rd_addr1.
- Port-2 row: r2=rd_addr2+BANK_OFFSET, computed in 17 bits, no truncation.
- Out of range: any row >= DEPTH returns all-zero data for that port and sets its rd_err bit. Rows in ROWS_USED..DEPTH-1 are legal.
- Read and write to the same row in the same cycle: read-before-write. The read returns the old row; new data is visible from the next read.
- Reset mid-stream drops the partial row pointer. Rows already written remain.

Decomposition:
- Shared package cnn_mem_pkg:
  - lane/row index typedefs
  - ROW_W = WORD_W*LANES
  - default layer constants (ROWS_USED/BANK_OFFSET per layer)
- Sub-module weight_pack_ram: DEPTH x ROW_W simple dual-read / single-write array.
  - Per-lane write enable, registered reads, read-before-write.
  - Later swappable for an SRAM macro wrapper.
- Top level holds the pointer counters, flush/clear logic, offset adder, range check and rd_valid.

Test Plan:
- Defaults; write 0x0001..0x0190 (400 words); read rd_addr1=0 -> rd_data1=lanes 0x0008..0x0001 (lane0=0x0001), rd_valid one cycle later; store_done=1 after word 400, wr_row=0, wr_lane=0.
- Read rd_addr1=3, rd_addr2=3 after full load -> rd_data1 lane0=0x0019, rd_data2 = row 28, lane0=0x00E1; rd_err=2'b00.
- rd_addr2=40 (40+25=65 >= 64) -> rd_data2=0, rd_err[1]=1; rd_addr1=70 -> rd_data1=0, rd_err[0]=1.
- Write 3 words then wr_flush -> wr_row=1, wr_lane=0; row 0 lanes 3..7 unchanged. wr_en+wr_flush on lane 7 -> single row advance.
- Write 5 words, assert rst=0 mid-cycle asynchronously -> all outputs 0 immediately. wr_clear with wr_en -> word dropped, store_done=0.
- Same-cycle read and write of row 2 lane 0 -> read shows old value; the next read shows the new one.
